// File: rtl/bit_serial_adder.sv
// Bit-serial adder front-end: one sum bit per clock, LSB first.
// Optional signed-overflow output: define BIT_SERIAL_ADDER_OVERFLOW_EN.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  input  logic             ack,
  output logic             busy,
  output logic             done,
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s, c_nx;
  logic             load, last;

  assign s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nx = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) |
                (b_sr[0] & carry);
  assign last = (cnt == CW'(WIDTH - 1));
  assign load = (state == IDLE && start) ||
                (state == DONE && ack && start);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = DONE;
      DONE: if (ack)   state_nx = start ? RUN : IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  // flags decoded from the state register only
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // shift registers, carry and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a_in;
      b_sr   <= b_in;
      sum_sr <= '0;
      carry  <= cin_in;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {s, sum_sr[WIDTH-1:1]};
      carry  <= c_nx;
      cnt    <= cnt + 1'b1;
    end
  end

  // result registers, updated on the final RUN edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else if (state == RUN && last) begin
      sum_out  <= {s, sum_sr[WIDTH-1:1]};
      cout_out <= c_nx;
    end
  end

`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
  // overflow: carry into MSB xor carry out of MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= carry ^ c_nx;
    else if (state == DONE && ack && start)
      ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH = 8).
// Build with BIT_SERIAL_ADDER_OVERFLOW_EN to also check ovf.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       cin_in;
  logic       ack;
  logic       busy, done;
  logic [7:0] sum_out;
  logic       cout_out;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    .ovf      (ovf),
`endif
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // count edges from the accept edge until done, with a bound
  task automatic wait_done(input string tag, output int n);
    int busy_low;
    n = 0;
    busy_low = 0;
    while (!done && n < 20) begin
      if (!busy) busy_low++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, busy_low, 0);
    chk({tag, "_lat"}, n, 8);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_done_low", {31'd0, done}, 0);
  endtask

  task automatic run(input string tag, input logic [7:0] a,
                     input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic ec,
                     input logic eo);
    int n;
    a_in = a; b_in = b; cin_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in = 8'hEE; b_in = 8'hEE; cin_in = 1'b0;
    wait_done(tag, n);
    chk({tag, "_sum"}, {24'd0, sum_out}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout_out}, {31'd0, ec});
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unused");
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; ack = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sum", {24'd0, sum_out}, 0);
    chk("rst_cout", {31'd0, cout_out}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    do_ack();
    chk("idle_sum_hold", {24'd0, sum_out}, 0);
    run("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_ack();
    chk("idle_cout_hold", {31'd0, cout_out}, 1);
    run("mix", 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1);
    do_ack();
    run("ovf7f", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_ack();

    // start during RUN must not reload
    a_in = 8'h22; b_in = 8'h33; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a_in = 8'h11; b_in = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat", n, 8);
    chk("ign_sum", {24'd0, sum_out}, 32'h55);
    a_in = 8'h01; b_in = 8'h01; start = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_done", {31'd0, done}, 1);
    chk("hold_sum", {24'd0, sum_out}, 32'h55);
    start = 1'b0;

    // ack and start together: straight back to RUN
    ack = 1'b1; start = 1'b1;
    a_in = 8'h80; b_in = 8'h80; cin_in = 1'b0;
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    chk("ab_done", {31'd0, done}, 0);
    chk("ab_busy", {31'd0, busy}, 1);
    wait_done("ab", n);
    chk("ab_sum", {24'd0, sum_out}, 0);
    chk("ab_cout", {31'd0, cout_out}, 1);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    chk("ab_ovf", {31'd0, ovf}, 1);
`endif
    do_ack();

    // asynchronous reset in the middle of RUN
    a_in = 8'h12; b_in = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_done", {31'd0, done}, 0);
    chk("mr_sum", {24'd0, sum_out}, 0);
    chk("mr_cout", {31'd0, cout_out}, 0);
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    chk("mr_ovf", {31'd0, ovf}, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_idle", {31'd0, busy | done}, 0);
    run("fresh", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential front-end that drives the team's 1-bit full-adder cell. It adds two WIDTH-bit operands, one bit per clock, LSB first.
- A single carry flip-flop feeds the cell's cout back into its cin on the next cycle.
- The block sits directly upstream of the full-adder cell and presents its result with a start/done/ack handshake.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; sampled only in IDLE or DONE
- a_in  input  WIDTH  operand A; captured on the edge that accepts start
- b_in  input  WIDTH  operand B; captured with a_in
- cin_in  input  1  initial carry-in; captured with a_in
- ack  input  1  consumer acknowledges the result; sampled only in DONE
- busy  output  1  high while in RUN
- done  output  1  high while in DONE; sum_out and cout_out are valid
- sum_out  output  WIDTH  result bits, LSB = bit 0
- cout_out  output  1  final carry-out

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: state = IDLE, busy = 0, done = 0, sum_out = 0, cout_out = 0, carry register = 0, bit counter = 0.
- State IDLE:
  - start = 1 at an edge loads the A/B shift registers from a_in/b_in and the carry register from cin_in.
  - The same edge clears the sum shift register and the counter, and moves to RUN.
- State RUN (busy = 1):
  - Each edge computes s = a[0] ^ b[0] ^ c and c_next = (a&b) | (a&c) | (b&c) on the current LSBs.
  - s shifts into the sum register MSB; A and B shift right; the carry register takes c_next; the counter increments.
  - On the edge where the counter equals WIDTH-1, move to DONE. sum_out and cout_out (the final carry) update on that same edge.
- Latency: done rises exactly WIDTH edges after the edge that accepted start. A back-to-back cycle time is WIDTH+1 edges minimum.
- State DONE (done = 1):
  - Outputs hold stable until ack = 1.
  - On ack with start = 0, go to IDLE; done drops on that edge. sum_out and cout_out keep their last value.
  - On ack and start in the same cycle, go directly to RUN with the new operands; done drops and busy rises on that edge.
  - start without ack is ignored; the result is never overwritten unacknowledged.
- start during RUN is ignored: operands are not reloaded and the current addition is not disturbed.
- ack outside DONE is ignored.
- Reset asserted mid-operation immediately forces all reset values; the partial result is discarded.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry on cout_out. {cout_out, sum_out} must equal a_in + b_in + cin_in exactly.
- busy and done are never high together; both are registered (no combinational path from inputs).

Optional Feature:
- Macro: BIT_SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output ovf (1 bit, reset 0), updated with sum_out on entry to DONE.
  - ovf = carry into the MSB XOR carry out of the MSB, i.e. two's-complement signed overflow.
  - ovf holds with the result and clears only on reset or on the edge that moves DONE to RUN.
- Not defined: port ovf does not exist, and all other behaviour is identical.

Test Plan:
- Zero case: WIDTH = 8, a_in = 0x00, b_in = 0x00, cin_in = 0, one-cycle start → done high exactly 8 edges later; sum_out = 0x00, cout_out = 0; busy high for those 8 cycles.
- Full carry ripple: a_in = 0xFF, b_in = 0x01, cin_in = 0 → sum_out = 0x00, cout_out = 1. A second case, a_in = 0x5A, b_in = 0x3C, cin_in = 1 → sum_out = 0x97, cout_out = 0.
- start ignored in RUN: start pulsed at RUN cycle 3 with a_in = 0x11 → result still that of the first operands. Hold done without ack for 5 cycles while start = 1 → result unchanged.
- Combined ack + start: in DONE, assert ack and start together with a_in = 0x80, b_in = 0x80, cin_in = 0 → next edge done = 0, busy = 1; 8 edges later sum_out = 0x00, cout_out = 1.
- Reset mid-operation: assert reset asynchronously (between edges) at RUN cycle 4 → all outputs 0 immediately, state IDLE. A fresh start then yields a correct result.
- Overflow (macro defined):
  - a_in = 0x7F, b_in = 0x01 → sum_out = 0x80, ovf = 1.
  - a_in = 0xFF, b_in = 0x01 → ovf = 0, cout_out = 1.
